mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, memory word width.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 20, memory address width.
REQ-003 The block SHALL have parameter WAIT, default 2, number of ACCESS cycles per transaction, legal range 1..15.
REQ-004 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports req0, req1  input  1 each  access request from requester 0 / 1.
REQ-007 The block SHALL have ports we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 The block SHALL have ports addr0, addr1  input  ADDRWIDTH each  word address.
REQ-009 The block SHALL have ports wdata0, wdata1  input  DATAWIDTH each  write data.
REQ-010 The block SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 The block SHALL have port rdata  output  DATAWIDTH  registered read data, shared by both requesters.
REQ-012 The block SHALL have port busy  output  1  high in ACCESS and ACK states.
REQ-013 The block SHALL have port mem_write_n  output  1  memory write strobe, active-low.
REQ-014 The block SHALL have port mem_enable_n  output  1  memory output enable, active-low.
REQ-015 The block SHALL have ports mem_addr  output  ADDRWIDTH and mem_in  output  DATAWIDTH  memory address and write data.
REQ-016 The block SHALL have port mem_out  input  DATAWIDTH  memory read data, combinational from mem_addr while mem_enable_n is low.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and ACK.
REQ-018 IDLE SHALL move to ACCESS on any rising edge where req0 or req1 is high; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: on a single request, that requester wins; on both requests, the requester not granted last wins.
REQ-020 A 1-bit last_grant register SHALL update to the winner at the IDLE->ACCESS edge.
REQ-021 At the IDLE->ACCESS edge, the winner's addr, wdata and we SHALL be latched into mem_addr, mem_in and an internal we register.
REQ-022 mem_addr and mem_in SHALL stay stable until the next grant.
REQ-023 ACCESS SHALL last exactly WAIT cycles, counted by a 4-bit down-counter loaded with WAIT-1, then move to ACK.
REQ-024 mem_enable_n SHALL be low in every ACCESS cycle and high in IDLE and ACK.
REQ-025 mem_write_n SHALL be low only in the last ACCESS cycle of a write, giving exactly one memory write per transaction, and high otherwise.
REQ-026 On a read, rdata SHALL capture mem_out at the edge ending the last ACCESS cycle.
REQ-027 rdata SHALL remain unchanged on writes and between transactions.
REQ-028 In ACK, the granted requester's ack SHALL be high for exactly one cycle, the other ack SHALL stay low, and the FSM SHALL return to IDLE.
REQ-029 Latency: for a request sampled at edge E0, ack SHALL be high in the cycle beginning WAIT+1 edges after E0.
REQ-030 Requests SHALL be ignored in ACCESS and ACK; a losing requester SHALL keep req high and is served in a later IDLE.
REQ-031 A requester SHALL hold req, we, addr and wdata stable from assertion until ack, and SHALL drop req at the edge ending its ack cycle unless it issues a new request.
REQ-032 busy SHALL be high exactly in ACCESS and ACK.
REQ-033 With both requesters continuously requesting, grants SHALL strictly alternate, with no starvation.

Reset
REQ-034 While rst is high, the block SHALL immediately force state=IDLE, mem_write_n=1, mem_enable_n=1, ack0=ack1=0, busy=0, rdata=0, mem_addr=0, mem_in=0, counter=0 and last_grant=1, so requester 0 wins the first contention.
REQ-035 Reset asserted during ACCESS SHALL abort the transaction with no memory write, no ack and no rdata update.

Verification
REQ-036 WAIT=2, req0 write addr 0x00010 data 0xBEEF -> mem_write_n low only in 2nd ACCESS cycle; ack0 high 3 edges after sampling; ack1 stays 0.
REQ-037 Then req1 read addr 0x00010 -> rdata=0xBEEF in the ack1 cycle; mem_write_n stays 1 throughout.
REQ-038 After reset, req0 and req1 asserted on the same cycle, both held until acked -> ack0 pulses first, then ack1 on the next transaction; busy drops for one IDLE cycle between them.
REQ-039 req0 and req1 held high continuously for 6 transactions -> ack order 0,1,0,1,0,1.
REQ-040 WAIT=2, rst pulsed during the 2nd ACCESS cycle of a write of 0x1234 to 0x00020 -> mem_write_n never low; no ack; a subsequent read of 0x00020 returns the prior contents.
REQ-041 WAIT=1, req1 read -> ack1 high 2 edges after sampling; mem_enable_n low for exactly 1 cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter that lets two requesters share one asynchronous-style
// memory. A grant latches the winner's address, data and direction. The
// memory is then enabled for WAIT cycles. A one-cycle ack goes back to the
// winner.
//
// Ports
//   clk, rst          : system clock (rising edge), async active-high reset
//   req0/req1         : access requests, held until the matching ack
//   we0/we1           : 1 = write, 0 = read
//   addr0/addr1       : word addresses
//   wdata0/wdata1     : write data
//   ack0/ack1         : one-cycle completion pulses
//   rdata             : registered read data, shared by both requesters
//   busy              : high while a transaction is in ACCESS or ACK
//   mem_write_n       : active-low write strobe, low only in the last ACCESS cycle of a write
//   mem_enable_n      : active-low output enable, low in every ACCESS cycle
//   mem_addr, mem_in  : latched address and write data, stable until the next grant
//   mem_out           : combinational read data from the memory
module mem_arbiter #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 20,
  parameter int WAIT      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [DATAWIDTH-1:0] wdata0,
  input  logic [DATAWIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 busy,
  output logic                 mem_write_n,
  output logic                 mem_enable_n,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_in,
  input  logic [DATAWIDTH-1:0] mem_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0] state;
  logic [3:0] count;
  logic       last_grant;
  logic       we_r;
  logic       winner;

  // Under contention the requester that was not served last goes next.
  // last_grant resets to 1, so requester 0 wins the first contention.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1)
      winner = ~last_grant;
    else if (req1)
      winner = 1'b1;
  end

  // last_grant changes only at a grant, so during ACCESS/ACK it also
  // identifies the requester currently being served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 4'd0;
      last_grant <= 1'b1;
      we_r       <= 1'b0;
      mem_addr   <= '0;
      mem_in     <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ACCESS;
            count      <= 4'(WAIT - 1);
            last_grant <= winner;
            we_r       <= winner ? we1 : we0;
            mem_addr   <= winner ? addr1 : addr0;
            mem_in     <= winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            state <= ACK;
            if (!we_r)
              rdata <= mem_out;
          end else begin
            count <= count - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The strobes are decoded from registered state only. The write strobe
  // qualifies on count==0, so each write transaction produces exactly one
  // memory write.
  assign busy         = (state == ACCESS) || (state == ACK);
  assign mem_enable_n = ~(state == ACCESS);
  assign mem_write_n  = ~((state == ACCESS) && (count == 4'd0) && we_r);
  assign ack0         = (state == ACK) && !last_grant;
  assign ack1         = (state == ACK) && last_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The main instance (WAIT=2) drives a
// 4K-word behavioural memory. It runs directed scenarios and a randomized
// sequence of single and contending requests. Results are compared with a
// transaction-level model that holds the expected memory contents, the
// round-robin pointer and the expected read data. A second instance with
// WAIT=1 covers the minimum-latency case.
module tb_mem_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 20;
  localparam int WAITA = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, memWriteN, memEnableN;
  logic [DW-1:0] rdata, memIn, memOut;
  logic [AW-1:0] memAddr;

  logic          reqB0, reqB1, weB0, weB1;
  logic [AW-1:0] addrB0, addrB1;
  logic [DW-1:0] wdataB0, wdataB1;
  logic          ackB0, ackB1, busyB, memWriteNB, memEnableNB;
  logic [DW-1:0] rdataB, memInB, memOutB;
  logic [AW-1:0] memAddrB;

  mem_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .WAIT(WAITA)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_write_n(memWriteN), .mem_enable_n(memEnableN),
    .mem_addr(memAddr), .mem_in(memIn), .mem_out(memOut)
  );

  mem_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .WAIT(1)) dutB (
    .clk(clk), .rst(rst),
    .req0(reqB0), .req1(reqB1), .we0(weB0), .we1(weB1),
    .addr0(addrB0), .addr1(addrB1), .wdata0(wdataB0), .wdata1(wdataB1),
    .ack0(ackB0), .ack1(ackB1), .rdata(rdataB), .busy(busyB),
    .mem_write_n(memWriteNB), .mem_enable_n(memEnableNB),
    .mem_addr(memAddrB), .mem_in(memInB), .mem_out(memOutB)
  );

  // Behavioural memory for the main instance. Reads are combinational.
  // Writes land on the rising edge that ends a cycle with the strobe low.
  logic [DW-1:0] mem [0:4095];
  assign memOut = memEnableN ? '0 : mem[memAddr[11:0]];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    forever begin
      @(posedge clk);
      if (!memWriteN) mem[memAddr[11:0]] = memIn;
    end
  end

  // The WAIT=1 instance reads from a fixed address-derived pattern.
  assign memOutB = memEnableNB ? '0 : (memAddrB[15:0] ^ 16'h5A5A);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] refMem [0:4095];
  int            mLast;
  logic [DW-1:0] expRdata;

  // Observations gathered by applyStimulus.
  int            lat0, lat1, enLowCnt, wrLowCnt, wrCyc, idleGap, firstId, spurious;
  logic [DW-1:0] rd0, rd1;
  bit            bothAck;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one or two requests on the same edge and hold each until acked.
  // Then drop it at the edge that ends its ack cycle.
  task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int   start;
    logic p0, p1;
    bit   done0, done1;
    @(posedge clk); #1;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    start = cyc;
    p0 = r0; p1 = r1;
    lat0 = -1; lat1 = -1; enLowCnt = 0; wrLowCnt = 0; wrCyc = -1;
    idleGap = 0; firstId = -1; spurious = 0; bothAck = 0;
    rd0 = '0; rd1 = '0;
    for (int k = 0; k < 40 && (p0 || p1); k++) begin
      @(negedge clk);
      done0 = 0; done1 = 0;
      if (!memEnableN) enLowCnt++;
      if (!memWriteN) begin
        wrLowCnt++;
        if (wrCyc < 0) wrCyc = cyc - start;
      end
      if (!busy && k > 0) idleGap++;
      if (ack0 && ack1) bothAck = 1;
      if (ack0 && !p0) spurious++;
      if (ack1 && !p1) spurious++;
      if (ack0 && p0) begin
        lat0 = cyc - start; rd0 = rdata; done0 = 1;
        if (firstId < 0) firstId = 0;
      end
      if (ack1 && p1) begin
        lat1 = cyc - start; rd1 = rdata; done1 = 1;
        if (firstId < 0) firstId = 1;
      end
      @(posedge clk); #1;
      if (done0) begin req0 = 0; p0 = 0; end
      if (done1) begin req1 = 0; p1 = 0; end
    end
    if (p0 || p1) begin
      checkOutput("ack_timeout", 1, 0);
      req0 = 0; req1 = 0;
    end
  endtask

  // Run one stimulus and compare it with the transaction-level model.
  // Requests are served in round-robin order, one every WAIT+2 cycles. A read
  // returns the model memory. rdata holds its value across writes.
  task automatic runTxn(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            order [2];
    int            n, nWr, expWr, id;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    applyStimulus(r0, r1, w0, w1, a0, a1, d0, d1);
    n = 0;
    if (r0 && r1) begin
      order[0] = 1 - mLast; order[1] = mLast; n = 2;
    end else if (r0) begin
      order[0] = 0; n = 1;
    end else if (r1) begin
      order[0] = 1; n = 1;
    end
    nWr = 0; expWr = -1;
    for (int pos = 0; pos < n; pos++) begin
      id = order[pos];
      a  = id ? a1 : a0;
      d  = id ? d1 : d0;
      w  = id ? w1 : w0;
      checkOutput(id ? "latency1" : "latency0", id ? lat1 : lat0, WAITA + 1 + pos * (WAITA + 2));
      if (w) begin
        nWr++;
        if (expWr < 0) expWr = WAITA + pos * (WAITA + 2);
        refMem[a[11:0]] = d;
      end else begin
        expRdata = refMem[a[11:0]];
      end
      checkOutput(id ? "rdata_at_ack1" : "rdata_at_ack0", int'(id ? rd1 : rd0), int'(expRdata));
      mLast = id;
    end
    if (n == 2) checkOutput("first_winner", firstId, order[0]);
    checkOutput("enable_cycles", enLowCnt, n * WAITA);
    checkOutput("write_cycles", wrLowCnt, nWr);
    checkOutput("write_position", wrCyc, expWr);
    checkOutput("idle_gap", idleGap, (n == 2) ? 1 : 0);
    checkOutput("spurious_ack", spurious, 0);
    checkOutput("dual_ack", int'(bothAck), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    mLast = 1;
    expRdata = '0;
  endtask

  initial begin
    int            n, k, start, lat, enB, ackB0Cnt;
    int            ord [6];
    int            ackCyc [6];
    int            exp;
    int            pat;
    logic [DW-1:0] rdB;
    bit            seenW, seenAck;

    for (int i = 0; i < 4096; i++) refMem[i] = 16'(i) ^ 16'hA5A5;
    rst = 1;
    req0 = 0; req1 = 1; we0 = 1; we1 = 0;
    addr0 = 20'h00ABC; addr1 = 20'h00DEF; wdata0 = 16'h7777; wdata1 = 16'h8888;
    reqB0 = 0; reqB1 = 0; weB0 = 0; weB1 = 0;
    addrB0 = '0; addrB1 = '0; wdataB0 = '0; wdataB1 = '0;
    mLast = 1; expRdata = '0;

    // Reset holds every output at its reset value even with a request
    // pending and the clock running.
    req0 = 1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ack0", ack0, 0);
    checkOutput("reset_ack1", ack1, 0);
    checkOutput("reset_write_n", memWriteN, 1);
    checkOutput("reset_enable_n", memEnableN, 1);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_mem_addr", memAddr, 0);
    checkOutput("reset_mem_in", memIn, 0);
    req0 = 0; req1 = 0;
    rst = 0;

    $display("[TB] directed write then read");
    runTxn(1, 0, 1, 0, 20'h00010, '0, 16'hBEEF, '0);
    checkOutput("mem_written", mem[12'h010], 16'hBEEF);
    runTxn(0, 1, 0, 0, '0, 20'h00010, '0, '0);
    checkOutput("mem_addr_held", memAddr, 20'h00010);

    $display("[TB] contention after reset");
    doReset();
    runTxn(1, 1, 0, 1, 20'h00010, 20'h00040, '0, 16'h4444);

    $display("[TB] continuous contention");
    doReset();
    @(posedge clk); #1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h00030; addr1 = 20'h00031;
    n = 0;
    for (k = 0; k < 80 && n < 6; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ord[n] = ack1 ? 1 : 0;
        ackCyc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    checkOutput("cont_ack_count", n, 6);
    for (int i = 0; i < n; i++) begin
      exp = 1 - mLast;
      checkOutput("cont_order", ord[i], exp);
      mLast = exp;
      if (i > 0) checkOutput("cont_spacing", ackCyc[i] - ackCyc[i-1], WAITA + 2);
    end
    expRdata = refMem[(mLast == 1) ? 12'h031 : 12'h030];
    checkOutput("cont_rdata", rdata, expRdata);

    $display("[TB] reset during access");
    runTxn(1, 0, 1, 0, 20'h00020, '0, 16'hCAFE, '0);
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 20'h00020; wdata0 = 16'h1234;
    seenW = 0; seenAck = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_first_access_en", memEnableN, 0);
    if (!memWriteN) seenW = 1;
    @(posedge clk);
    rst = 1;
    @(negedge clk);
    if (!memWriteN) seenW = 1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_enable_n", memEnableN, 1);
    checkOutput("abort_rdata", rdata, 0);
    req0 = 0;
    rst = 0;
    mLast = 1; expRdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!memWriteN) seenW = 1;
      if (ack0 || ack1) seenAck = 1;
    end
    checkOutput("abort_no_write", int'(seenW), 0);
    checkOutput("abort_no_ack", int'(seenAck), 0);
    checkOutput("abort_mem_kept", mem[12'h020], 16'hCAFE);
    runTxn(0, 1, 0, 0, '0, 20'h00020, '0, '0);

    $display("[TB] randomized requests");
    for (int t = 0; t < 30; t++) begin
      pat = $urandom_range(0, 2);
      runTxn(pat != 1, pat != 0, 1'($urandom), 1'($urandom),
             20'($urandom_range(0, 15)), 20'($urandom_range(0, 15)),
             16'($urandom), 16'($urandom));
    end

    $display("[TB] WAIT=1 read");
    @(posedge clk); #1;
    reqB1 = 1; weB1 = 0; addrB1 = 20'h00777;
    start = cyc; lat = -1; enB = 0; ackB0Cnt = 0; rdB = '0;
    for (k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!memEnableNB) enB++;
      if (ackB0) ackB0Cnt++;
      if (ackB1) begin
        lat = cyc - start;
        rdB = rdataB;
      end
    end
    @(posedge clk); #1;
    reqB1 = 0;
    checkOutput("w1_latency", lat, 2);
    checkOutput("w1_enable_cycles", enB, 1);
    checkOutput("w1_rdata", rdB, 16'h0777 ^ 16'h5A5A);
    checkOutput("w1_ack0", ackB0Cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
